// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command constants and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        TX_ACK     = 2'b00,
        TX_NACK    = 2'b01,
        TX_TIMEOUT = 2'b10
    } tx_status_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: multi-stage synchronizer for PS/2 lines plus falling-edge pulse on bit 0 (the clock line).
module ps2_sync #(
    parameter int W      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         clk_fall
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];
    logic         prev_q, prev_d;

    // Shift the raw levels through the chain and remember the last synced clock level.
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync_q[STAGES-1][0];
    end

    // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout     = sync_q[STAGES-1];
    assign clk_fall = prev_q & ~dout[0];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN enables automatic resend on NACK/TIMEOUT.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int SETUP_CYCLES   = 500,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam int CW = $clog2((INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int BW = $clog2(10) + 1;

    if (MAX_RETRIES < 0 || SYNC_STAGES < 1 || INHIBIT_CYCLES < 1 || SETUP_CYCLES < 1) begin : g_bad_cfg
        $error("ps2_host_tx: invalid parameter set");
    end

    tx_state_t     state_q, state_d;
    tx_status_t    result_q, result_d;
    logic [9:0]    shift_q, shift_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          finish, timed;
    logic          clk_s, data_s, clk_fall;
`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    logic [RW-1:0] retries_q, retries_d;
    logic [7:0]    byte_q, byte_d;
`endif

    ps2_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk_100mhz),
        .rst      (rst),
        .din      ({ps2_data_in, ps2_clk_in}),
        .dout     ({data_s, clk_s}),
        .clk_fall (clk_fall)
    );

    // Next-state logic: phase timing, bit shifting on device clock falls, timeout and completion.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        finish    = 1'b0;
        timed     = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
`ifdef PS2_TX_RETRY_EN
        retries_d = retries_q;
        byte_d    = byte_q;
`endif
        case (state_q)
            ST_IDLE: if (tx_valid) begin
                state_d  = ST_INHIBIT;
                shift_d  = {1'b1, odd_parity(tx_data), tx_data};
                clk_oe_d = 1'b1;
                cnt_d    = '0;
`ifdef PS2_TX_RETRY_EN
                byte_d    = tx_data;
                retries_d = '0;
`endif
            end
            ST_INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                state_d   = ST_REQ;
                cnt_d     = '0;
                data_oe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_REQ: if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                state_d  = ST_SHIFT;
                clk_oe_d = 1'b0;
                tmo_d    = '0;
                bitcnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase
        if (timed) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                result_d = TX_TIMEOUT;
                finish   = 1'b1;
            end else if (state_q == ST_SHIFT && clk_fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b1, shift_q[9:1]};
                bitcnt_d  = bitcnt_q + 1'b1;
                state_d   = (bitcnt_q == BW'(9)) ? ST_ACK : ST_SHIFT;
            end else if (state_q == ST_ACK && clk_fall) begin
                result_d = data_s ? TX_NACK : TX_ACK;
                state_d  = ST_WAIT_IDLE;
            end else if (state_q == ST_WAIT_IDLE && clk_s && data_s) begin
                finish = 1'b1;
            end
        end
        if (finish) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_DONE;
`ifdef PS2_TX_RETRY_EN
            if (result_d != TX_ACK && retries_q < RW'(MAX_RETRIES)) begin
                state_d   = ST_INHIBIT;
                clk_oe_d  = 1'b1;
                cnt_d     = '0;
                shift_d   = {1'b1, odd_parity(byte_q), byte_q};
                retries_d = retries_q + 1'b1;
            end
`endif
        end
    end

    // State and datapath registers; reset drops both lines immediately with no completion pulse.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= TX_ACK;
            shift_q   <= '1;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retries_q <= '0;
            byte_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
            retries_q <= retries_d;
            byte_q    <= byte_d;
`endif
        end
    end

    assign tx_ready    = (state_q == ST_IDLE) && !rst;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign status      = done ? result_q : TX_ACK;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with an open-drain PS/2 device model and frame reference model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int SET = 10;
    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
    logic [1:0] status;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         inh_cnt = 0;
    logic       clk_oe_prev = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2),
        .MAX_RETRIES    (2)
    ) dut (
        .clk_100mhz  (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .status      (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        clk_oe_prev <= ps2_clk_oe;
        if (ps2_clk_oe && !clk_oe_prev) inh_cnt <= inh_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line levels seen by the device at rising edges: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        int t;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("inhibit_clk", ps2_clk_oe, 1);
        t = 0;
        while (!ps2_data_oe && t < INH + SET + 10) begin
            tick();
            t++;
        end
        check("t_req", t, INH);
        tx_data  = ~d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        t++;
        while (ps2_clk_oe && t < INH + SET + 10) begin
            tick();
            t++;
        end
        check("t_release", t, INH + SET);
        check("start_held", ps2_data_oe, 1);
    endtask

    task automatic wait_release();
        int t;
        t = 0;
        while (!ps2_clk_oe && t < 50) begin
            tick();
            t++;
        end
        while (ps2_clk_oe && t < INH + SET + 100) begin
            tick();
            t++;
        end
        check("release", ps2_clk_oe, 0);
    endtask

    task automatic dev_frame(input int h, input bit ack, input int nfall, output logic [10:0] got);
        got = '1;
        for (int i = 0; i < nfall; i++) begin
            tick(h);
            if (i == 0) got[0] = ps2_data_in;
            dev_clk_low = 1'b1;
            tick(h);
            dev_clk_low = 1'b0;
            if (i < 10) got[i+1] = ps2_data_in;
            if (i == 9) dev_data_low = ack;
            if (i == 10) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(output logic [1:0] st);
        int t;
        t = 0;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        check("done_seen", done, 1);
        st = status;
        tick();
        check("done_pulse", done, 0);
        check("ready_after", tx_ready, 1);
    endtask

    task automatic run_frame(input logic [7:0] d, input int h, input bit ack);
        logic [10:0] got;
        logic [1:0]  st;
        int          dc;
        dc = done_cnt;
        send(d);
        dev_frame(h, ack, 11, got);
        check("frame", got, frame_of(d));
        wait_done(st);
        check("status", st, ack ? 2'b00 : 2'b01);
        tick(5);
        check("one_done", done_cnt - dc, 1);
        check("ignored_req", busy, 0);
    endtask

`ifdef PS2_TX_RETRY_EN
    task automatic retry_run(input logic [7:0] d, input logic [2:0] acks, input logic [1:0] exp_st);
        logic [10:0] got;
        logic [1:0]  st;
        int          dc, ic;
        dc = done_cnt;
        ic = inh_cnt;
        send(d);
        for (int a = 0; a < 3; a++) begin
            if (a > 0) wait_release();
            dev_frame(25, acks[a], 11, got);
            check("retry_frame", got, frame_of(d));
        end
        wait_done(st);
        check("retry_status", st, exp_st);
        tick(3);
        check("retry_inhibits", inh_cnt - ic, 3);
        check("retry_one_done", done_cnt - dc, 1);
    endtask
`endif

    initial begin
        logic [10:0] got;
        int          dc, t;
        tick(3);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_ready", tx_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_first", tx_ready, 1);
        tick(2);

        run_frame(CMD_SET_LEDS, 25, 1'b1);
        run_frame(8'h01, 22, 1'b1);
        run_frame(CMD_RESET, 30, 1'b1);
        run_frame(8'h55, 28, 1'b0);
        for (int k = 0; k < 6; k++)
            run_frame(8'($urandom), $urandom_range(20, 40), 1'($urandom_range(0, 1)));

`ifndef PS2_TX_RETRY_EN
        send(8'hAA);
        t = 0;
        while (!done && t < TMO + 50) begin
            tick();
            t++;
        end
        check("t_timeout", t, TMO);
        check("tmo_status", status, 2'b10);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        tick();
        check("tmo_ready", tx_ready, 1);
`endif

        dc = done_cnt;
        send(8'h3C);
        dev_frame(25, 1'b1, 4, got);
        rst = 1'b1;
        tick();
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        tick(5);
        check("mid_rst_no_done", done_cnt - dc, 0);
        run_frame(CMD_ECHO, 25, 1'b1);

`ifdef PS2_TX_RETRY_EN
        retry_run(8'h9A, 3'b100, 2'b00);
        retry_run(8'h9A, 3'b000, 2'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
